// File: rtl/sort_pkg.sv
// Shared types and constants for the merge sorter tree.
// Holds the element/run defaults, the merge state encoding and a constant log2 helper.
package sort_pkg;

    localparam int unsigned ELEM_W_DEF  = 32;
    localparam int unsigned RUN_LEN_DEF = 16;

    typedef enum logic [1:0] {
        MERGE,
        DRAIN_A,
        DRAIN_B
    } merge_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/merge_cell_2way_if.sv
// Handshake bundle of a 2-way merge cell: two upstream enq/full streams and one downstream stream.
// The slave modport is the merge cell's view; the master modport is the surrounding tree's view.
interface merge_cell_2way_if
    import sort_pkg::*;
#(
    parameter int unsigned ELEM_W = ELEM_W_DEF
);
    logic [ELEM_W-1:0] din_a;
    logic              enq_a;
    logic              full_a;
    logic [ELEM_W-1:0] din_b;
    logic              enq_b;
    logic              full_b;
    logic [ELEM_W-1:0] dout;
    logic              enq;
    logic              dout_last;
    logic              full;

    modport slave (
        input  din_a, enq_a,
        output full_a,
        input  din_b, enq_b,
        output full_b,
        output dout, enq, dout_last,
        input  full
    );

    modport master (
        output din_a, enq_a,
        input  full_a,
        output din_b, enq_b,
        input  full_b,
        input  dout, enq, dout_last,
        output full
    );
endinterface

// File: rtl/merge_fifo.sv
// First-word-fall-through input buffer of a merge cell: DEPTH x ELEM_W, async active-high reset.
// A push while full is dropped; a pop while empty is ignored.
module merge_fifo
    import sort_pkg::*;
#(
    parameter int unsigned ELEM_W = ELEM_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] din,
    input  logic              push,
    input  logic              pop,
    output logic [ELEM_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int unsigned    AW       = clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);

    logic [ELEM_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/merge_cell_2way.sv
// Leaf merge cell: merges pairs of sorted RUN_LEN runs from streams A and B into 2*RUN_LEN runs.
// Ascending by default; define MERGER_DESC_EN for a descending merge (same ports and timing).
module merge_cell_2way
    import sort_pkg::*;
#(
    parameter int unsigned ELEM_W  = ELEM_W_DEF,
    parameter int unsigned RUN_LEN = RUN_LEN_DEF,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    merge_cell_2way_if.slave  bus
);
    localparam int unsigned   CW       = clog2(RUN_LEN) + 1;
    localparam logic [CW-1:0] LAST_IN  = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(2 * RUN_LEN - 1);

    merge_state_t      state, state_nxt;
    logic [CW-1:0]     cnt_a, cnt_a_nxt;
    logic [CW-1:0]     cnt_b, cnt_b_nxt;
    logic [CW-1:0]     out_cnt;
    logic [ELEM_W-1:0] head_a, head_b;
    logic              empty_a, empty_b;
    logic              full_a, full_b;
    logic              sel_a, sel_valid;
    logic              enq_o, pop_a, pop_b;

    merge_fifo #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.din_a),
        .push  (bus.enq_a),
        .pop   (pop_a),
        .head  (head_a),
        .empty (empty_a),
        .full  (full_a)
    );

    merge_fifo #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.din_b),
        .push  (bus.enq_b),
        .pop   (pop_b),
        .head  (head_b),
        .empty (empty_b),
        .full  (full_b)
    );

    // Tie goes to A in both directions.
    function automatic logic take_a(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b);
`ifdef MERGER_DESC_EN
        return a >= b;
`else
        return a <= b;
`endif
    endfunction

    always_comb begin
        sel_a     = 1'b0;
        sel_valid = 1'b0;
        state_nxt = state;
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;

        case (state)
            MERGE: begin
                sel_a     = take_a(head_a, head_b);
                sel_valid = !empty_a && !empty_b;
            end
            DRAIN_A: begin
                sel_a     = 1'b1;
                sel_valid = !empty_a;
            end
            DRAIN_B: begin
                sel_a     = 1'b0;
                sel_valid = !empty_b;
            end
            default: begin
                sel_a     = 1'b0;
                sel_valid = 1'b0;
            end
        endcase

        enq_o = !bus.full && sel_valid;
        pop_a = enq_o && sel_a;
        pop_b = enq_o && !sel_a;

        if (pop_a) cnt_a_nxt = cnt_a + CW'(1);
        if (pop_b) cnt_b_nxt = cnt_b + CW'(1);

        // Next-run elements stay parked in the buffers until both counters are cleared here.
        case (state)
            MERGE: begin
                if (pop_a && cnt_a == LAST_IN)      state_nxt = DRAIN_B;
                else if (pop_b && cnt_b == LAST_IN) state_nxt = DRAIN_A;
            end
            DRAIN_A: begin
                if (pop_a && cnt_a == LAST_IN) begin
                    state_nxt = MERGE;
                    cnt_a_nxt = '0;
                    cnt_b_nxt = '0;
                end
            end
            DRAIN_B: begin
                if (pop_b && cnt_b == LAST_IN) begin
                    state_nxt = MERGE;
                    cnt_a_nxt = '0;
                    cnt_b_nxt = '0;
                end
            end
            default: state_nxt = MERGE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MERGE;
            cnt_a   <= '0;
            cnt_b   <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt_a   <= cnt_a_nxt;
            cnt_b   <= cnt_b_nxt;
            if (enq_o) out_cnt <= out_cnt + CW'(1);
        end
    end

    assign bus.full_a    = full_a;
    assign bus.full_b    = full_b;
    assign bus.enq       = enq_o;
    assign bus.dout      = sel_a ? head_a : head_b;
    assign bus.dout_last = enq_o && (out_cnt == LAST_OUT);

endmodule

// File: tb/tb_merge_cell_2way.sv
// Directed scoreboard bench for merge_cell_2way with RUN_LEN=4, DEPTH=4.
// With MERGER_DESC_EN defined, all data is mapped through v -> 1000-v so the same tables apply.
module tb_merge_cell_2way;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ds_full = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned exp_total   = 0;

    always #5 clk = ~clk;

    merge_cell_2way_if #(.ELEM_W(32)) bus ();

    merge_cell_2way #(.ELEM_W(32), .RUN_LEN(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] m(input int unsigned v);
`ifdef MERGER_DESC_EN
        return 32'(1000 - v);
`else
        return 32'(v);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic exp8(input int unsigned e0, input int unsigned e1, input int unsigned e2,
                        input int unsigned e3, input int unsigned e4, input int unsigned e5,
                        input int unsigned e6, input int unsigned e7);
        int unsigned v[8];
        exp_t e;
        v = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int i = 0; i < 8; i++) begin
            exp_total++;
            e.d    = m(v[i]);
            e.last = (exp_total % 8 == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic feed4(input bit to_a, input int unsigned v0, input int unsigned v1,
                         input int unsigned v2, input int unsigned v3);
        int unsigned v[4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            if (to_a) qa.push_back(m(v[i]));
            else      qb.push_back(m(v[i]));
        end
    endtask

    // Inputs change just after posedge, outputs are checked at negedge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        bus.enq_a = 1'b0;
        bus.enq_b = 1'b0;
        if (qa.size() > 0 && !bus.full_a) begin
            bus.enq_a = 1'b1;
            bus.din_a = qa.pop_front();
        end
        if (qb.size() > 0 && !bus.full_b) begin
            bus.enq_b = 1'b1;
            bus.din_b = qb.pop_front();
        end
        bus.full = ds_full;
        @(negedge clk);
        if (bus.enq) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL spurious_enq: observed dout %0d expected no output", bus.dout);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout", bus.dout, e.d);
                check("dout_last", 32'(bus.dout_last), 32'(e.last));
            end
        end
    endtask

    task automatic drain();
        ds_full = 1'b0;
        for (int i = 0; i < 200 && (exp_q.size() > 0 || qa.size() > 0 || qb.size() > 0); i++) begin
            tick();
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.din_a = '0;
        bus.din_b = '0;
        bus.enq_a = 1'b0;
        bus.enq_b = 1'b0;
        bus.full  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enq", 32'(bus.enq), 32'd0);
        check("rst_full_a", 32'(bus.full_a), 32'd0);
        check("rst_full_b", 32'(bus.full_b), 32'd0);
        check("rst_dout_last", 32'(bus.dout_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // basic merge
        exp8(1, 2, 3, 4, 6, 7, 8, 9);
        feed4(1'b1, 1, 4, 6, 9);
        feed4(1'b0, 2, 3, 7, 8);
        drain();

        // ties: first pop must come from A
        exp8(5, 5, 5, 5, 5, 5, 5, 5);
        feed4(1'b1, 5, 5, 5, 5);
        feed4(1'b0, 5, 5, 5, 5);
        ds_full = 1'b1;
        repeat (6) tick();
        check("tie_full_a", 32'(bus.full_a), 32'd1);
        check("tie_full_b", 32'(bus.full_b), 32'd1);
        ds_full = 1'b0;
        tick();
        ds_full = 1'b1;
        tick();
        check("tie_pop_a_full_a", 32'(bus.full_a), 32'd0);
        check("tie_pop_a_full_b", 32'(bus.full_b), 32'd1);
        drain();

        // early exhaust of A, B drains without bubble
        exp8(1, 2, 3, 4, 10, 11, 12, 13);
        feed4(1'b1, 1, 2, 3, 4);
        feed4(1'b0, 10, 11, 12, 13);
        ds_full = 1'b1;
        repeat (6) tick();
        ds_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_bubble", 32'(bus.enq), 32'd1);
        end
        drain();

        // backpressure mid-run with both buffers full
        exp8(1, 2, 3, 4, 6, 7, 8, 9);
        exp8(20, 21, 22, 23, 24, 25, 26, 27);
        feed4(1'b1, 1, 4, 6, 9);
        feed4(1'b1, 20, 21, 22, 23);
        feed4(1'b0, 2, 3, 7, 8);
        feed4(1'b0, 24, 25, 26, 27);
        ds_full = 1'b1;
        repeat (6) tick();
        ds_full = 1'b0;
        repeat (2) tick();
        ds_full = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_enq", 32'(bus.enq), 32'd0);
            check("bp_full_a", 32'(bus.full_a), 32'd1);
            check("bp_full_b", 32'(bus.full_b), 32'd1);
        end
        drain();

        // back-to-back runs: A run2 buffered while B run1 drains
        exp8(1, 2, 3, 4, 10, 11, 12, 13);
        exp8(0, 1, 5, 6, 7, 8, 20, 30);
        feed4(1'b1, 1, 2, 3, 4);
        feed4(1'b1, 0, 5, 20, 30);
        feed4(1'b0, 10, 11, 12, 13);
        feed4(1'b0, 1, 6, 7, 8);
        drain();

        // reset after three outputs
        exp8(1, 2, 3, 4, 6, 7, 8, 9);
        feed4(1'b1, 1, 4, 6, 9);
        feed4(1'b1, 50, 51, 52, 53);
        feed4(1'b0, 2, 3, 7, 8);
        ds_full = 1'b1;
        repeat (6) tick();
        ds_full = 1'b0;
        repeat (3) tick();
        check("pre_rst_enq", 32'(bus.enq), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_enq", 32'(bus.enq), 32'd0);
        check("mid_rst_full_a", 32'(bus.full_a), 32'd0);
        check("mid_rst_full_b", 32'(bus.full_b), 32'd0);
        check("mid_rst_dout_last", 32'(bus.dout_last), 32'd0);
        exp_q.delete();
        qa.delete();
        qb.delete();
        exp_total = 0;
        bus.enq_a = 1'b0;
        bus.enq_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp8(1, 2, 3, 5, 7, 11, 12, 13);
        feed4(1'b1, 3, 5, 7, 11);
        feed4(1'b0, 1, 2, 12, 13);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
